// File: rtl/keccak_pkg.sv
// Shared definitions for the SHAKE host-side input driver.
// Holds the word width, the supported mode codes, the header field
// positions, the driver FSM state type and a mode-check helper.
package keccak_pkg;

  localparam int w = 64;

  localparam logic [3:0] MODE_SHAKE256 = 4'h0;
  localparam logic [3:0] MODE_SHAKE128 = 4'h1;

  // Header layout: mode in [63:60], output length in [59:32], input length in [31:0]
  localparam int HDR_MODE_MSB = 63;
  localparam int HDR_OUT_MSB  = 59;
  localparam int HDR_IN_MSB   = 31;

  // Bit position inside a word and number of message words left
  localparam int TAIL_W = 6;
  localparam int WCNT_W = 27;

  typedef enum logic [1:0] {
    DRV_IDLE   = 2'd0,
    DRV_HEADER = 2'd1,
    DRV_STREAM = 2'd2,
    DRV_FINISH = 2'd3
  } drv_state_t;

  function automatic logic mode_supported(input logic [3:0] mode);
    return (mode == MODE_SHAKE256) || (mode == MODE_SHAKE128);
  endfunction

endpackage

// File: rtl/tail_masker.sv
// Zeroes the unused upper bits of a partial final message word.
// Ports:
//   tail_bits - number of valid low bits in the word; 0 means the whole word is valid
//   word_in   - raw message word
//   word_out  - word with bits [W-1:tail_bits] cleared
module tail_masker
  import keccak_pkg::*;
#(
  parameter int W = w
) (
  input  logic [TAIL_W-1:0] tail_bits,
  input  logic [W-1:0]      word_in,
  output logic [W-1:0]      word_out
);

  logic [W-1:0] keep_s;

  // Build the keep-mask and apply it
  always_comb begin
    keep_s = '1;
    if (tail_bits != '0) begin
      keep_s = ~({W{1'b1}} << tail_bits);
    end else begin
      keep_s = '1;
    end
    word_out = word_in & keep_s;
  end

endmodule

// File: rtl/shake_input_driver.sv
// Host-side transmitter for the SHAKE core input port.
// Accepts one hash command, emits the header word, then streams the
// message words from upstream into the core, masking the partial tail.
// Ports:
//   clk, rst                    - clock, async active-high reset
//   cmd_valid/cmd_ready         - command handshake (cmd_mode, cmd_out_len, cmd_in_len)
//   msg_valid/msg_ready/msg_data- upstream message word handshake
//   core_valid/core_ready/core_data - output word handshake towards the core
//   busy                        - FSM not idle
//   done                        - one-cycle pulse after the last word is taken
//   cmd_err                     - one-cycle pulse on an unsupported mode
module shake_input_driver
  import keccak_pkg::*;
#(
  parameter int W = w
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [3:0]   cmd_mode,
  input  logic [27:0]  cmd_out_len,
  input  logic [31:0]  cmd_in_len,
  input  logic         msg_valid,
  output logic         msg_ready,
  input  logic [W-1:0] msg_data,
  output logic         core_valid,
  input  logic         core_ready,
  output logic [W-1:0] core_data,
  output logic         busy,
  output logic         done,
  output logic         cmd_err
);

  drv_state_t        state_r;
  logic [WCNT_W-1:0] words_left_r;
  logic [TAIL_W-1:0] tail_bits_r;
  logic              core_valid_r;
  logic [W-1:0]      core_data_r;
  logic              done_r;
  logic              cmd_err_r;

  logic [WCNT_W-1:0] words_init_s;
  logic [W-1:0]      header_s;
  logic [TAIL_W-1:0] mask_bits_s;
  logic [W-1:0]      masked_s;
  logic              msg_ready_s;
  logic              core_fire_s;
  logic              msg_fire_s;

  // Command decode: word count, header word, handshake qualifiers
  always_comb begin
    // Round up to whole words; 33-bit sum so a 32-bit length cannot wrap
    words_init_s = WCNT_W'(({1'b0, cmd_in_len} + 33'd63) >> 6);
    header_s = '0;
    header_s[HDR_MODE_MSB -: 4]  = cmd_mode;
    header_s[HDR_OUT_MSB  -: 28] = cmd_out_len;
    header_s[HDR_IN_MSB   -: 32] = cmd_in_len;
    // Accept in HEADER as well so the first word follows the header without a bubble
    msg_ready_s = ((state_r == DRV_HEADER) || (state_r == DRV_STREAM)) &&
                  (words_left_r != '0) && (!core_valid_r || core_ready);
    core_fire_s = core_valid_r && core_ready;
    msg_fire_s  = msg_valid && msg_ready_s;
    if (words_left_r == WCNT_W'(1)) begin
      mask_bits_s = tail_bits_r;
    end else begin
      mask_bits_s = '0;
    end
  end

  tail_masker #(.W(W)) u_tail_masker (
    .tail_bits (mask_bits_s),
    .word_in   (msg_data),
    .word_out  (masked_s)
  );

  // Driver FSM and output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= DRV_IDLE;
      words_left_r <= '0;
      tail_bits_r  <= '0;
      core_valid_r <= 1'b0;
      core_data_r  <= '0;
      done_r       <= 1'b0;
      cmd_err_r    <= 1'b0;
    end else begin
      done_r    <= 1'b0;
      cmd_err_r <= 1'b0;
      case (state_r)
        DRV_IDLE: begin
          if (cmd_valid) begin
            if (mode_supported(cmd_mode)) begin
              words_left_r <= words_init_s;
              tail_bits_r  <= cmd_in_len[TAIL_W-1:0];
              core_data_r  <= header_s;
              core_valid_r <= 1'b1;
              state_r      <= DRV_HEADER;
            end else begin
              cmd_err_r <= 1'b1;
            end
          end
        end
        DRV_HEADER, DRV_STREAM: begin
          // A new load overrides the clear so back-to-back words keep core_valid high
          if (msg_fire_s) begin
            core_data_r  <= masked_s;
            core_valid_r <= 1'b1;
            words_left_r <= words_left_r - WCNT_W'(1);
          end else if (core_fire_s) begin
            core_valid_r <= 1'b0;
          end
          if (state_r == DRV_HEADER) begin
            if (core_fire_s) begin
              if (words_left_r == '0) begin
                state_r <= DRV_FINISH;
                done_r  <= 1'b1;
              end else begin
                state_r <= DRV_STREAM;
              end
            end
          end else if ((words_left_r == '0) && (core_fire_s || !core_valid_r)) begin
            state_r <= DRV_FINISH;
            done_r  <= 1'b1;
          end
        end
        DRV_FINISH: begin
          state_r <= DRV_IDLE;
        end
        default: begin
          state_r      <= DRV_IDLE;
          core_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready  = (state_r == DRV_IDLE);
  assign busy       = (state_r != DRV_IDLE);
  assign msg_ready  = msg_ready_s;
  assign core_valid = core_valid_r;
  assign core_data  = core_data_r;
  assign done       = done_r;
  assign cmd_err    = cmd_err_r;

endmodule
